// File: rtl/seq_alu.sv
// Multi-cycle ALU for the accumulator datapath: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide when SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100, OP_SHR = 4'b0101, OP_ROL = 4'b0110, OP_ROR = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000, OP_OR  = 4'b1001, OP_XOR = 4'b1010, OP_NOR = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100, OP_XNOR = 4'b1101, OP_GT = 4'b1110, OP_EQ = 4'b1111;

  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf, sc_zero;
  logic [WIDTH:0]   add_ext, sub_ext;

  always_comb begin
    add_ext  = {1'b0, operand1} + {1'b0, operand2};
    sub_ext  = {1'b0, operand1} - {1'b0, operand2};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_res   = add_ext[WIDTH-1:0];
        sc_carry = add_ext[WIDTH];
        sc_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (add_ext[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_ext[WIDTH-1:0];
        sc_carry = sub_ext[WIDTH];
        sc_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (sub_ext[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SHL:  begin sc_res = {operand1[WIDTH-2:0], 1'b0};              sc_carry = operand1[WIDTH-1]; end
      OP_SHR:  begin sc_res = {1'b0, operand1[WIDTH-1:1]};              sc_carry = operand1[0];       end
      OP_ROL:  begin sc_res = {operand1[WIDTH-2:0], operand1[WIDTH-1]}; sc_carry = operand1[WIDTH-1]; end
      OP_ROR:  begin sc_res = {operand1[0], operand1[WIDTH-1:1]};       sc_carry = operand1[0];       end
      OP_AND:  sc_res = operand1 & operand2;
      OP_OR:   sc_res = operand1 | operand2;
      OP_XOR:  sc_res = operand1 ^ operand2;
      OP_NOR:  sc_res = ~(operand1 | operand2);
      OP_NAND: sc_res = ~(operand1 & operand2);
      OP_XNOR: sc_res = ~(operand1 ^ operand2);
      OP_GT:   sc_res = WIDTH'(operand1 > operand2);
      OP_EQ:   sc_res = WIDTH'(operand1 == operand2);
      default: sc_res = '0;
    endcase
    // mul/div only reach this path in the engine-less build, where every flag stays low
    sc_zero = (sc_res == '0) && (opcode != OP_MUL) && (opcode != OP_DIV);
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic             is_div;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (!is_div) begin
      {nxt_hi, nxt_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      nxt_hi = div_diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE; cnt <= '0; acc_hi <= '0; acc_lo <= '0; mcand <= '0; is_div <= 1'b0;
      result <= '0; result_hi <= '0; done <= 1'b0;
      zero <= 1'b0; carry <= 1'b0; overflow <= 1'b0; div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (opcode == OP_MUL || (opcode == OP_DIV && operand2 != '0)) begin
            acc_hi <= '0;
            acc_lo <= operand1;
            mcand  <= operand2;
            is_div <= (opcode == OP_DIV);
            cnt    <= CW'(WIDTH - 1);
            state  <= RUN;
          end else if (opcode == OP_DIV) begin
            result <= '1; result_hi <= operand1; done <= 1'b1;
            zero <= 1'b0; carry <= 1'b0; overflow <= 1'b0; div_zero <= 1'b1;
          end else begin
            result <= sc_res; result_hi <= '0; done <= 1'b1;
            zero <= sc_zero; carry <= sc_carry; overflow <= sc_ovf; div_zero <= 1'b0;
          end
        end
        default: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == '0) begin
            state <= IDLE;
            result <= nxt_lo; result_hi <= nxt_hi; done <= 1'b1;
            zero <= (nxt_lo == '0); carry <= 1'b0;
            overflow <= !is_div && (nxt_hi != '0); div_zero <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end
`else
  assign busy     = 1'b0;
  assign div_zero = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0; result_hi <= '0; done <= 1'b0;
      zero <= 1'b0; carry <= 1'b0; overflow <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result <= sc_res; result_hi <= '0;
        zero <= sc_zero; carry <= sc_carry; overflow <= sc_ovf;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver pushes hand-computed expectations, and a
// negedge monitor pops one per done pulse and checks values, flags, latency and busy.
module tb_seq_alu;
  localparam int W = 16;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int ML = MD ? W : 0;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [3:0] opcode = '0;
  logic [W-1:0] operand1 = '0, operand2 = '0, result, result_hi;
  logic busy, done, zero, carry, overflow, div_zero;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .operand1(operand1), .operand2(operand2), .result(result), .result_hi(result_hi),
    .busy(busy), .done(done), .zero(zero), .carry(carry), .overflow(overflow),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [W-1:0] res, hi;
    logic z, c, o, dz;
    int lat, t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) busy_run = 0;
    else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {16'h0, result}, 32'hDEAD_0000);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".result"},    result, e.res);
          chk({e.name, ".result_hi"}, result_hi, e.hi);
          chk({e.name, ".zero"},      zero, e.z);
          chk({e.name, ".carry"},     carry, e.c);
          chk({e.name, ".overflow"},  overflow, e.o);
          chk({e.name, ".div_zero"},  div_zero, e.dz);
          chk({e.name, ".latency"},   cyc - e.t0, e.lat);
          chk({e.name, ".busy_cycles"}, busy_run, e.lat);
          chk({e.name, ".busy_at_done"}, busy, 1'b0);
        end
        busy_run = 0;
      end
    end
  end

  // Call just after a negedge; start is high for exactly one cycle.
  task automatic issue(string nm, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] res, logic [W-1:0] hi,
                       logic z, logic c, logic o, logic dz, int lat);
    exp_t e;
    opcode = op; operand1 = a; operand2 = b; start = 1'b1;
    e.name = nm; e.res = res; e.hi = hi; e.z = z; e.c = c; e.o = o; e.dz = dz;
    e.lat = lat; e.t0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".result"}, result, 0);
    chk({tag, ".result_hi"}, result_hi, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".flags"}, {zero, carry, overflow, div_zero}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;

    issue("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 1, 0, 0, 0); drain();
    issue("add_ovf",  4'h0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, 1, 0, 0); drain();
    issue("sub_borrow", 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 1, 0, 0, 0); drain();
    issue("sub_ovf",  4'h1, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, 0, 0); drain();
    issue("shl1",  4'h4, 16'h8001, 16'h0, 16'h0002, 0, 0, 1, 0, 0, 0); drain();
    issue("shr1",  4'h5, 16'h8001, 16'h0, 16'h4000, 0, 0, 1, 0, 0, 0); drain();
    issue("rotl1", 4'h6, 16'h8001, 16'h0, 16'h0003, 0, 0, 1, 0, 0, 0); drain();
    issue("rotr1", 4'h7, 16'h0002, 16'h0, 16'h0001, 0, 0, 0, 0, 0, 0); drain();
    issue("and",  4'h8, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0, 0, 0); drain();
    issue("or",   4'h9, 16'hF0F0, 16'h0FF0, 16'hFFF0, 0, 0, 0, 0, 0, 0); drain();
    issue("xor",  4'hA, 16'hF0F0, 16'h0FF0, 16'hFF00, 0, 0, 0, 0, 0, 0); drain();
    issue("nor",  4'hB, 16'hF0F0, 16'h0FF0, 16'h000F, 0, 0, 0, 0, 0, 0); drain();
    issue("nand", 4'hC, 16'hF0F0, 16'h0FF0, 16'hFF0F, 0, 0, 0, 0, 0, 0); drain();
    issue("xnor", 4'hD, 16'hF0F0, 16'h0FF0, 16'h00FF, 0, 0, 0, 0, 0, 0); drain();
    issue("gt_true",  4'hE, 16'h0005, 16'h0003, 16'h0001, 0, 0, 0, 0, 0, 0); drain();
    issue("gt_false", 4'hE, 16'h0003, 16'h0005, 16'h0000, 0, 1, 0, 0, 0, 0); drain();
    issue("eq_true",  4'hF, 16'h1234, 16'h1234, 16'h0001, 0, 0, 0, 0, 0, 0); drain();

    // 300*300 = 0x0001_5F90; a start pulsed mid-run must be ignored
    issue("mul_300", 4'h2, 16'd300, 16'd300, MD ? 16'h5F90 : 16'h0, MD ? 16'h0001 : 16'h0,
          0, 0, MD, 0, ML);
`ifdef SEQ_ALU_MULDIV_EN
    repeat (3) @(negedge clk);
    opcode = 4'h0; operand1 = 16'h0001; operand2 = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`endif
    drain();

    issue("mul_max", 4'h2, 16'hFFFF, 16'hFFFF, MD ? 16'h0001 : 16'h0, MD ? 16'hFFFE : 16'h0,
          0, 0, MD, 0, ML);
    drain();
    issue("div_1000_7", 4'h3, 16'd1000, 16'd7, MD ? 16'h008E : 16'h0, MD ? 16'h0006 : 16'h0,
          0, 0, 0, 0, ML);
    drain();
    issue("div_by_zero", 4'h3, 16'd5, 16'd0, MD ? 16'hFFFF : 16'h0, MD ? 16'h0005 : 16'h0,
          0, 0, 0, MD, 0);
    drain();

    // back-to-back: next start presented in the done cycle of a mul
    issue("mul_3x4", 4'h2, 16'd3, 16'd4, MD ? 16'h000C : 16'h0, 16'h0, 0, 0, 0, 0, ML);
    begin
      bit seen = 0;
      if (done) seen = 1;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("b2b_done_seen", seen, 1);
    end
    issue("b2b_add", 4'h0, 16'h0010, 16'h0020, 16'h0030, 0, 0, 0, 0, 0, 0);
    drain();

    // reset mid-operation after a nonzero result is on the outputs
    issue("pre_reset_xor", 4'hA, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 0, 0, 0); drain();
`ifdef SEQ_ALU_MULDIV_EN
    issue("aborted_mul", 4'h2, 16'd300, 16'd300, 0, 0, 0, 0, 0, 0, W);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", busy, 1);
`endif
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    check_all_zero("held_reset");
    reset = 1'b1;
    issue("post_reset_add", 4'h0, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 0, 0);
    drain();
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
